// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the shared ALU operand selects, PC/IR/ALUOut enables, RF write-back and memory port.
module multicycle_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic        i_mem_ready,
  input  logic        i_br_taken,
  output logic        o_ir_we,
  output logic        o_pc_we,
  output logic        o_pc_src,
  output logic        o_alu_out_we,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_mem_addr_sel,
  output logic [1:0]  o_alusrc_a,
  output logic [1:0]  o_alusrc_b,
  output logic [1:0]  o_alu_ctl,
  output logic        o_rf_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_illegal,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t     r_state;
  logic       r_illegal;
  logic [6:0] w_opcode;
  logic       w_legal;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_unused_instr;

  assign w_opcode       = i_instr[6:0];
  assign w_is_load      = (w_opcode == OP_LOAD);
  assign w_is_store     = (w_opcode == OP_STORE);
  // Only the opcode steers sequencing; the remaining fields belong to the datapath.
  assign w_unused_instr = ^i_instr[31:7];
  assign o_state        = r_state;
  assign o_illegal      = r_illegal;

  always_comb begin
    w_legal = 1'b0;
    case (w_opcode)
      OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR: w_legal = 1'b1;
      default:                    w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_mem_ready) r_state <= S_DECODE;
          else             r_state <= S_FETCH;
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          case (w_opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: r_state <= S_WB;
            OP_LOAD, OP_STORE:            r_state <= S_MEM;
            OP_BRANCH, OP_JAL, OP_JALR:   r_state <= S_FETCH;
            default: begin
              r_state   <= S_TRAP;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (!i_mem_ready) r_state <= S_MEM;
          else if (w_is_load) r_state <= S_WB;
          else r_state <= S_FETCH;
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Reset holds every strobe and select low, even though the state already reads FETCH.
  always_comb begin
    o_ir_we        = 1'b0;
    o_pc_we        = 1'b0;
    o_pc_src       = 1'b0;
    o_alu_out_we   = 1'b0;
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr_sel = 1'b0;
    o_alusrc_a     = 2'b00;
    o_alusrc_b     = 2'b00;
    o_alu_ctl      = 2'b00;
    o_rf_we        = 1'b0;
    o_wb_sel       = 2'b00;
    if (i_rst) begin
      o_mem_req = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          o_mem_req  = 1'b1;
          o_alusrc_a = 2'b11;
          o_alusrc_b = 2'b10;
          if (i_mem_ready) begin
            o_ir_we = 1'b1;
            o_pc_we = 1'b1;
          end else begin
            o_ir_we = 1'b0;
          end
        end
        S_DECODE: begin
          o_alusrc_a   = 2'b01;
          o_alusrc_b   = 2'b01;
          o_alu_out_we = 1'b1;
        end
        S_EXEC: begin
          case (w_opcode)
            OP_R: begin
              o_alu_ctl    = 2'b10;
              o_alu_out_we = 1'b1;
            end
            OP_I: begin
              o_alusrc_b   = 2'b01;
              o_alu_ctl    = 2'b10;
              o_alu_out_we = 1'b1;
            end
            OP_LUI: begin
              o_alusrc_a   = 2'b10;
              o_alusrc_b   = 2'b01;
              o_alu_out_we = 1'b1;
            end
            OP_AUIPC: begin
              o_alusrc_a   = 2'b01;
              o_alusrc_b   = 2'b01;
              o_alu_out_we = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
              o_alusrc_b   = 2'b01;
              o_alu_out_we = 1'b1;
            end
            OP_BRANCH: begin
              o_alu_ctl = 2'b01;
              if (i_br_taken) begin
                o_pc_we  = 1'b1;
                o_pc_src = 1'b1;
              end else begin
                o_pc_we  = 1'b0;
              end
            end
            OP_JAL, OP_JALR: begin
              o_alusrc_a = (w_opcode == OP_JAL) ? 2'b01 : 2'b00;
              o_alusrc_b = 2'b01;
              o_pc_we    = 1'b1;
              o_rf_we    = 1'b1;
              o_wb_sel   = 2'b10;
            end
            default: o_alu_ctl = 2'b00;
          endcase
        end
        S_MEM: begin
          o_mem_req      = 1'b1;
          o_mem_addr_sel = 1'b1;
          o_mem_we       = w_is_store;
        end
        S_WB: begin
          o_rf_we  = 1'b1;
          o_wb_sel = w_is_load ? 2'b01 : 2'b00;
        end
        S_TRAP:  o_mem_req = 1'b0;
        default: o_mem_req = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle and
// compares every output against hand-derived per-state values.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        br_taken;
  logic        ir_we, pc_we, pc_src, alu_out_we, mem_req, mem_we, mem_addr_sel;
  logic [1:0]  alusrc_a, alusrc_b, alu_ctl, wb_sel;
  logic        rf_we, illegal;
  logic [2:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_mem_ready(mem_ready),
    .i_br_taken(br_taken), .o_ir_we(ir_we), .o_pc_we(pc_we), .o_pc_src(pc_src),
    .o_alu_out_we(alu_out_we), .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_mem_addr_sel(mem_addr_sel), .o_alusrc_a(alusrc_a), .o_alusrc_b(alusrc_b),
    .o_alu_ctl(alu_ctl), .o_rf_we(rf_we), .o_wb_sel(wb_sel), .o_illegal(illegal),
    .o_state(state)
  );

  always #5 clk = ~clk;

  // Fields packed as {state,ir,pcwe,pcsrc,aluwe,req,we,asel,a,b,ctl,rf,wb,ill}.
  task automatic cyc(input string tag, input logic [2:0] st, input logic ir, input logic pw,
                     input logic ps, input logic aw, input logic rq, input logic mw,
                     input logic ms, input logic [1:0] a, input logic [1:0] b,
                     input logic [1:0] c, input logic rw, input logic [1:0] wb,
                     input logic il);
    logic [19:0] obs, exp;
    @(negedge clk);
    exp = {st, ir, pw, ps, aw, rq, mw, ms, a, b, c, rw, wb, il};
    obs = {state, ir_we, pc_we, pc_src, alu_out_we, mem_req, mem_we, mem_addr_sel,
           alusrc_a, alusrc_b, alu_ctl, rf_we, wb_sel, illegal};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok(input string tag);
    cyc(tag, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0);
  endtask
  task automatic fetch_wait(input string tag);
    cyc(tag, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0);
  endtask
  task automatic decode(input string tag);
    cyc(tag, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; mem_ready = 1'b0; br_taken = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    cyc("reset_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);

    // add x2,x1,x3
    rst = 1'b0; mem_ready = 1'b1; instr = 32'h00308133;
    fetch_ok("add_fetch");
    decode("add_decode");
    cyc("add_exec", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 2'b00, 1'b0);
    cyc("add_wb", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);

    // lw with two MEM wait cycles
    instr = 32'h0000A103;
    fetch_ok("lw_fetch");
    decode("lw_decode");
    cyc("lw_exec", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0);
    mem_ready = 1'b0;
    cyc("lw_mem_w1", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    cyc("lw_mem_w2", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    mem_ready = 1'b1;
    cyc("lw_mem_done", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    cyc("lw_wb", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0);

    // sw, with one FETCH wait cycle
    instr = 32'h0020A023; mem_ready = 1'b0;
    fetch_wait("sw_fetch_wait");
    mem_ready = 1'b1;
    fetch_ok("sw_fetch");
    decode("sw_decode");
    cyc("sw_exec", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0);
    cyc("sw_mem", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);

    // beq taken
    instr = 32'h00208463; br_taken = 1'b1;
    fetch_ok("sw_next_fetch_beq");
    decode("beq_t_decode");
    cyc("beq_t_exec", 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0);
    // beq not taken
    br_taken = 1'b0;
    fetch_ok("beq_n_fetch");
    decode("beq_n_decode");
    cyc("beq_n_exec", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0);

    // jal
    instr = 32'h008000EF;
    fetch_ok("jal_fetch");
    decode("jal_decode");
    cyc("jal_exec", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 2'b10, 1'b0);
    // jalr
    instr = 32'h000080E7;
    fetch_ok("jalr_fetch");
    decode("jalr_decode");
    cyc("jalr_exec", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 2'b10, 1'b0);
    // lui
    instr = 32'h123450B7;
    fetch_ok("lui_fetch");
    decode("lui_decode");
    cyc("lui_exec", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0);
    cyc("lui_wb", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0);

    // illegal opcode, sticky TRAP
    instr = 32'h0000007F;
    fetch_ok("ill_fetch");
    decode("ill_decode");
    cyc("trap_1", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1);
    cyc("trap_2", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1);
    rst = 1'b1;
    cyc("trap_rst", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1);
    cyc("trap_rst_done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);

    // reset in the middle of a stalled FETCH
    rst = 1'b0; mem_ready = 1'b0; instr = 32'h00308133;
    fetch_wait("midf_wait1");
    fetch_wait("midf_wait2");
    rst = 1'b1; mem_ready = 1'b1;
    cyc("midf_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    rst = 1'b0; mem_ready = 1'b0;
    fetch_wait("midf_restart");
    mem_ready = 1'b1;
    fetch_ok("midf_fetch");
    decode("midf_decode");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
